// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the KAN datapath arithmetic blocks.
// Flag bit positions, bias, special encodings and the divider state type.
package bf16_pkg;

    localparam int FLAG_NAN  = 3;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_NORM = 0;

    localparam int BIAS = 127;

    localparam logic [14:0] QNAN_MAG = 15'h7FFF;
    localparam logic [14:0] INF_MAG  = 15'h7F80;
    localparam logic [14:0] ZERO_MAG = 15'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bf16_class.sv
// Splits a bfloat16 word into sign, exponent and significand with hidden bit.
// It also produces a one-hot class flag. Subnormals are reported as ZERO.
module bf16_class
    import bf16_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 7,
    parameter int FLAG_WIDTH = 4
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0] data,
    output logic                         sign,
    output logic [EXP_WIDTH-1:0]         exp,
    output logic [SIG_WIDTH:0]           sig,
    output logic [FLAG_WIDTH-1:0]        flag
);

    logic [SIG_WIDTH-1:0] mant;
    logic                 exp_max;
    logic                 exp_min;

    assign sign    = data[EXP_WIDTH+SIG_WIDTH];
    assign exp     = data[EXP_WIDTH+SIG_WIDTH-1:SIG_WIDTH];
    assign mant    = data[SIG_WIDTH-1:0];
    assign sig     = {1'b1, mant};
    assign exp_max = &exp;
    assign exp_min = ~|exp;

    always_comb begin
        flag = '0;
        if (exp_max && (mant != '0)) begin
            flag[FLAG_NAN] = 1'b1;
        end else if (exp_max) begin
            flag[FLAG_INF] = 1'b1;
        end else if (exp_min) begin
            flag[FLAG_ZERO] = 1'b1;
        end else begin
            flag[FLAG_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/bf16_div.sv
// Sequential bfloat16 divider: restoring radix-2 significand loop, one bit per cycle.
// Special operands resolve at the accept edge; normal operands take 9 DIV cycles plus NORM.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for operands; specials go straight to DONE
//   DIV   | one restoring quotient bit per cycle, counter 8 down to 0
//   NORM  | normalise quotient, compute exponent, detect over/underflow
//   DONE  | result valid and held until the consumer takes it
module bf16_div
    import bf16_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 7,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_data_a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_data_b,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0] o_data,
    output logic [FLAG_WIDTH-1:0]        o_flag
);

    localparam int DW = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int RW = SIG_WIDTH + 3;
    localparam int QW = SIG_WIDTH + 2;
    localparam int EW = EXP_WIDTH + 2;

    localparam logic signed [EW-1:0] BIAS_HI  = EW'(BIAS);
    localparam logic signed [EW-1:0] BIAS_LO  = EW'(BIAS - 1);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic [3:0]           CNT_INIT = 4'(SIG_WIDTH + 1);

    state_t state, next_state;

    logic [DW-1:0]         a_q, b_q;
    logic                  sign_q;
    logic [RW-1:0]         rem;
    logic [QW-1:0]         quo;
    logic [3:0]            cnt;

    logic [DW-1:0]         op_a, op_b;
    logic                  sign_a, sign_b;
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [SIG_WIDTH:0]    sig_a, sig_b;
    logic [FLAG_WIDTH-1:0] flag_a, flag_b;

    logic                  accept;
    logic                  normal;
    logic                  sign_in;
    logic [DW-1:0]         spec_data;
    logic [FLAG_WIDTH-1:0] spec_flag;

    logic [RW-1:0]         divisor;
    logic                  q_bit;
    logic [RW-1:0]         rem_diff;
    logic [RW-1:0]         rem_next;

    logic signed [EW-1:0]  exp_calc;
    logic [SIG_WIDTH-1:0]  norm_man;
    logic [DW-1:0]         norm_data;
    logic [FLAG_WIDTH-1:0] norm_flag;

    // Classifiers look at the live inputs while idle so specials are known at accept.
    assign op_a = (state == IDLE) ? i_data_a : a_q;
    assign op_b = (state == IDLE) ? i_data_b : b_q;

    bf16_class #(
        .EXP_WIDTH  (EXP_WIDTH),
        .SIG_WIDTH  (SIG_WIDTH),
        .FLAG_WIDTH (FLAG_WIDTH)
    ) u_class_a (
        .data (op_a),
        .sign (sign_a),
        .exp  (exp_a),
        .sig  (sig_a),
        .flag (flag_a)
    );

    bf16_class #(
        .EXP_WIDTH  (EXP_WIDTH),
        .SIG_WIDTH  (SIG_WIDTH),
        .FLAG_WIDTH (FLAG_WIDTH)
    ) u_class_b (
        .data (op_b),
        .sign (sign_b),
        .exp  (exp_b),
        .sig  (sig_b),
        .flag (flag_b)
    );

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign accept  = o_ready && i_valid;
    assign normal  = flag_a[FLAG_NORM] && flag_b[FLAG_NORM];
    assign sign_in = sign_a ^ sign_b;

    always_comb begin
        spec_data = '0;
        spec_flag = '0;
        if (flag_a[FLAG_NAN] || flag_b[FLAG_NAN] ||
            (flag_a[FLAG_ZERO] && flag_b[FLAG_ZERO]) ||
            (flag_a[FLAG_INF] && flag_b[FLAG_INF])) begin
            spec_data           = {sign_in, QNAN_MAG};
            spec_flag[FLAG_NAN] = 1'b1;
        end else if (flag_a[FLAG_INF] || flag_b[FLAG_ZERO]) begin
            spec_data           = {sign_in, INF_MAG};
            spec_flag[FLAG_INF] = 1'b1;
        end else begin
            spec_data            = {sign_in, ZERO_MAG};
            spec_flag[FLAG_ZERO] = 1'b1;
        end
    end

    assign divisor  = {2'b00, sig_b};
    assign q_bit    = (rem >= divisor);
    assign rem_diff = q_bit ? (rem - divisor) : rem;
    assign rem_next = rem_diff << 1;

    // Quotient lies in (0.5, 2): bit 8 set means it is already in [1, 2).
    assign exp_calc = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                    + (quo[QW-1] ? BIAS_HI : BIAS_LO);
    assign norm_man = quo[QW-1] ? quo[QW-2:1] : quo[QW-3:0];

    always_comb begin
        norm_data = '0;
        norm_flag = '0;
        if (exp_calc >= EXP_OVF) begin
            norm_data           = {sign_q, INF_MAG};
            norm_flag[FLAG_INF] = 1'b1;
        end else if (exp_calc <= 0) begin
            norm_data            = {sign_q, ZERO_MAG};
            norm_flag[FLAG_ZERO] = 1'b1;
        end else begin
            norm_data            = {sign_q, exp_calc[EXP_WIDTH-1:0], norm_man};
            norm_flag[FLAG_NORM] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    next_state = normal ? DIV : DONE;
                end
            end
            DIV: begin
                if (cnt == 4'd0) begin
                    next_state = NORM;
                end
            end
            NORM: next_state = DONE;
            DONE: begin
                if (i_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            o_data <= '0;
            o_flag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= i_data_a;
                        b_q    <= i_data_b;
                        sign_q <= sign_in;
                        rem    <= {2'b00, sig_a};
                        quo    <= '0;
                        cnt    <= CNT_INIT;
                        if (!normal) begin
                            o_data <= spec_data;
                            o_flag <= spec_flag;
                        end
                    end
                end
                DIV: begin
                    quo <= {quo[QW-2:0], q_bit};
                    rem <= rem_next;
                    cnt <= cnt - 4'd1;
                end
                NORM: begin
                    o_data <= norm_data;
                    o_flag <= norm_flag;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: directed corner table plus randomized operands.
// Expected results come from an integer-division model of the bf16 divide rules.
module tb_bf16_div;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] i_data_a = 16'h0000;
    logic [15:0] i_data_b = 16'h0000;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic [3:0]  o_flag;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];

    bf16_div dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_flag   (o_flag)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit both_normal(input logic [15:0] a, input logic [15:0] b);
        return (a[14:7] != 8'h00) && (a[14:7] != 8'hFF) &&
               (b[14:7] != 8'h00) && (b[14:7] != 8'hFF);
    endfunction

    // Returns {flag, data}. The quotient significand is floor(A*256/B).
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, q, sig, e;
        logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [7:0] e8;
        logic [6:0] m7;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = int'(a[6:0]);
        mb = int'(b[6:0]);
        s  = a[15] ^ b[15];
        nan_a  = (ea == 255) && (ma != 0);
        nan_b  = (eb == 255) && (mb != 0);
        inf_a  = (ea == 255) && (ma == 0);
        inf_b  = (eb == 255) && (mb == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            return {4'b1000, s, 15'h7FFF};
        if (inf_a || zero_b)
            return {4'b0010, s, 15'h7F80};
        if (zero_a || inf_b)
            return {4'b0100, s, 15'h0000};
        q = ((128 + ma) * 256) / (128 + mb);
        if (q >= 256) begin
            sig = q / 2;
            e   = ea - eb + 127;
        end else begin
            sig = q;
            e   = ea - eb + 126;
        end
        if (e >= 255)
            return {4'b0010, s, 15'h7F80};
        if (e <= 0)
            return {4'b0100, s, 15'h0000};
        e8 = 8'(e);
        m7 = 7'(sig);
        return {4'b0001, s, e8, m7};
    endfunction

    always @(negedge i_clk) begin
        logic [19:0] e;
        if (!i_rst && o_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stale_result: got data %h flag %b expected no result", o_data, o_flag);
            end else if (i_ready) begin
                e = exp_q.pop_front();
                check("result", {12'h000, o_flag, o_data}, {12'h000, e});
                check("onehot", 32'($onehot(o_flag)), 32'd1);
            end
        end
    end

    task automatic op(input logic [15:0] a, input logic [15:0] b, input int hold);
        int lat;
        logic [15:0] d0;
        logic [3:0]  f0;
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        exp_q.push_back(model(a, b));
        @(posedge i_clk); #1;
        i_valid  = 1'b0;
        i_data_a = 16'($urandom);
        i_data_b = 16'($urandom);
        lat = 1;
        while (!o_valid && lat < 30) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check("latency", 32'(lat), both_normal(a, b) ? 32'd11 : 32'd1);
        if (!o_valid) begin
            exp_q.delete();
            return;
        end
        d0 = o_data;
        f0 = o_flag;
        for (int i = 0; i < hold; i++) begin
            check("hold_ready_low", 32'(o_ready), 32'd0);
            i_valid  = 1'($urandom);
            i_data_a = 16'($urandom);
            i_data_b = 16'($urandom);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            check("hold_data", 32'(o_data), 32'(d0));
            check("hold_flag", 32'(o_flag), 32'(f0));
            check("hold_valid", 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("ready_after_handshake", 32'(o_ready), 32'd1);
        check("valid_after_handshake", 32'(o_valid), 32'd0);
    endtask

    function automatic logic [15:0] rand_operand();
        logic [15:0] x;
        int r;
        x = 16'($urandom);
        r = $urandom_range(0, 9);
        if (r < 7)
            x[14:7] = 8'($urandom_range(100, 154));
        else if (r == 7)
            x[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        return x;
    endfunction

    logic [15:0] tab_a [11] = '{16'h3FC0, 16'h3F80, 16'h40C0, 16'h40A0, 16'h0000, 16'h7F80,
                                16'h3F80, 16'h7F00, 16'h0080, 16'h0001, 16'h4000};
    logic [15:0] tab_b [11] = '{16'h3FC0, 16'h4040, 16'hC000, 16'h0000, 16'h8000, 16'h7F80,
                                16'h7F80, 16'h3E80, 16'h4000, 16'h3F80, 16'h3F80};
    logic [15:0] tab_d [11] = '{16'h3F80, 16'h3EAA, 16'hC040, 16'h7F80, 16'hFFFF, 16'h7FFF,
                                16'h0000, 16'h7F80, 16'h0000, 16'h0000, 16'h4000};
    logic [3:0]  tab_f [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b1000,
                                4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0001};

    initial begin
        for (int i = 0; i < 11; i++)
            check("model_pin", {12'h000, model(tab_a[i], tab_b[i])}, {12'h000, tab_f[i], tab_d[i]});

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_data", 32'(o_data), 32'h0000);
        check("reset_flag", 32'(o_flag), 32'h0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("ready_after_reset", 32'(o_ready), 32'd1);

        for (int i = 0; i < 11; i++)
            op(tab_a[i], tab_b[i], (i == 1 || i == 4) ? 5 : 0);

        // Abort in the middle of the divide loop.
        i_valid  = 1'b1;
        i_data_a = 16'h3FC0;
        i_data_b = 16'h4040;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_data", 32'(o_data), 32'h0000);
        check("abort_flag", 32'(o_flag), 32'h0);
        repeat (15) @(posedge i_clk);
        #1;
        check("abort_still_idle", 32'(o_ready), 32'd1);
        op(16'h4000, 16'h3F80, 0);

        for (int n = 0; n < 200; n++)
            op(rand_operand(), rand_operand(), $urandom_range(0, 3));

        repeat (3) @(posedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf16_div.md
Name: bf16_div

Overview:
Sequential bfloat16 divider (quotient = i_data_a / i_data_b), the inverse-operation companion to the combinational bf16 multiplier in the KAN datapath. Computes the significand quotient with a radix-2 restoring loop, one quotient bit per cycle. Uses the same classification, special-value rules and 4-bit one-hot flag encoding as the multiplier. Valid/ready on both sides; one operation in flight.

Parameters:
EXP_WIDTH, 8, exponent field width
SIG_WIDTH, 7, stored significand width (hidden bit excluded)
FLAG_WIDTH, 4, flag vector width: bit3 NAN, bit2 ZERO, bit1 INF, bit0 NORM

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset
i_valid  in  1  operands valid
o_ready  out  1  divider can accept operands; high iff state IDLE
i_data_a  in  16  dividend, bf16
i_data_b  in  16  divisor, bf16
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_data  out  16  quotient, bf16
o_flag  out  4  one-hot result class

Behaviour:
- One clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values: state IDLE, o_valid 0, o_data 0x0000, o_flag 0000, so o_ready=1 on the first cycle after reset. Reset mid-operation aborts with no output.
- FSM states and transitions:
  - IDLE: on i_valid&&o_ready, register the operands and sign = a[15]^b[15], then classify.
  - Special case: go to DONE next edge (latency 1).
  - Otherwise: go to DIV.
  - DIV: 9 iterations, counter 8 down to 0. Remainder R starts at {1,ma}, divisor D = {1,mb}. Each iteration: q_bit = (R >= D); R = (q_bit ? R-D : R) << 1. R is 10 bits wide.
  - NORM: one cycle, then DONE.
  - DONE: o_valid=1 and outputs held stable until i_ready. On o_valid&&i_ready, return to IDLE with o_valid=0 at that edge.
- Latency: 11 edges from accept to o_valid for normal operands (1 accept + 9 DIV + 1 NORM); 1 edge for special cases. No accept while busy; i_valid outside IDLE is ignored.
- Classification: exp==0xFF with mant!=0 is NaN; 0xFF with mant==0 is INF; exp==0 is ZERO (subnormals flush to zero); everything else is NORM.
- Special-case priority:
  1. Either operand NaN, 0/0, or INF/INF: o_data {sign,15'h7FFF}, NAN flag.
  2. a INF, or b ZERO: o_data {sign,8'hFF,7'h00}, INF flag.
  3. a ZERO, or b INF: o_data {sign,15'h0000}, ZERO flag.
- Normal path:
  - q[8:0] is the quotient, MSB first.
  - If q[8]=1: sig = q[8:1], e = ea - eb + 127.
  - Else: sig = q[7:0], e = ea - eb + 126.
  - Rounding is truncation (toward zero); no sticky bit.
  - e is computed in 10-bit signed arithmetic.
  - e >= 255: INF result and flag.
  - e <= 0: signed zero, ZERO flag.
  - Otherwise: o_data {sign, e[7:0], sig[6:0]}, NORM flag.
- o_flag is always exactly one-hot while o_valid=1.

Decomposition:
- Shared package bf16_pkg:
  - Flag indices NAN=3, ZERO=2, INF=1, NORM=0.
  - BIAS=127.
  - Encodings QNAN_MAG=15'h7FFF, INF_MAG=15'h7F80.
  - FSM state enum IDLE/DIV/NORM/DONE.
- Reuse the existing bf16_class sub-module, instanced twice on the registered operands, for flags, exponent, significand and sign. The divide loop stays inline; no further sub-modules.

Test Plan:
- 0x3FC0/0x3FC0 (1.5/1.5) -> 0x3F80, flag 0001, o_valid 11 edges after accept.
- 0x3F80/0x4040 (1/3) -> 0x3EAA (truncated), flag 0001. 0x40C0/0xC000 (6/-2) -> 0xC040.
- Specials, each with latency 1:
  - 0x40A0/0x0000 -> 0x7F80, flag 0010.
  - 0x0000/0x8000 -> 0xFFFF, flag 1000.
  - 0x7F80/0x7F80 -> 0x7FFF, flag 1000.
  - 0x3F80/0x7F80 -> 0x0000, flag 0100.
- Range limits:
  - 0x7F00/0x3E80 -> 0x7F80, flag 0010 (overflow).
  - 0x0080/0x4000 -> 0x0000, flag 0100 (underflow flush).
  - 0x0001 dividend treated as zero.
- Backpressure: hold i_ready=0 for 5 cycles in DONE. o_data/o_flag must stay stable, o_ready=0, and i_valid pulses are ignored. The i_ready handshake gives o_ready=1 the next cycle.
- Assert i_rst at DIV iteration 4 -> next cycle o_valid=0, o_ready=1, o_data 0x0000, and no stale result ever appears. A following 0x4000/0x3F80 gives 0x4000.
